trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Machine-mode trap controller that owns the single write port of `csr_handler`, sequencing its CSR updates for exception entry, interrupt entry and `mret`. Sits between the pipeline's writeback-stage CSR write port and `csr_handler`: it forwards pipeline CSR writes when idle, and otherwise performs one CSR write per cycle (mepc, mcause, mtval, mstatus). It then redirects fetch to the trap vector or to mepc.

## Interface
- `XLEN`, 32, data width; only 32 is supported.
- `VECTORED_EN`, 1, honour mtvec MODE=01 for interrupts; 0 forces direct mode.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `exc_valid` in 1 — synchronous exception from the faulting instruction, single-cycle pulse.
- `exc_cause` in 4 — exception code (0–15).
- `exc_tval` in 32 — trap value.
- `trap_pc` in 32 — PC of the faulting instruction, or the next unretired PC for interrupts.
- `irq_ext`, `irq_timer` in 1 each — level-sensitive interrupt lines.
- `mret_valid` in 1 — `mret` retiring, pulse.
- `mstatus_i`, `mie_i`, `mtvec_i`, `mepc_i` in 32 each — current CSR values read from `csr_handler`.
- `pipe_wben`, `pipe_wbaddr[11:0]`, `pipe_wbdata[31:0]` in — pipeline CSR write request.
- `csr_wben`, `csr_wbaddr[11:0]`, `csr_wbdata[31:0]` out — registered write port to `csr_handler`.
- `stall` out 1 — pipeline hold while sequencing.
- `flush` out 1 — one-cycle pipeline flush pulse.
- `redirect_valid` out 1, `redirect_pc` out 32 — fetch redirect pulse and its target.

## Operation
- **States:** IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS, REDIRECT.
- **Request evaluation in IDLE.** Priority: `exc_valid` > external IRQ > timer IRQ > `mret_valid`.
  - An IRQ is pending only when `mstatus_i[3]` (MIE) is set and the matching enable bit is set: `mie_i[11]` for external, `mie_i[7]` for timer.
  - On acceptance, latch cause, tval and `trap_pc`.
  - mcause = `{1'b0, 27'b0, exc_cause}` for exceptions, `32'h8000000B` for external, `32'h80000007` for timer.
  - tval = 0 for interrupts.
- **Trap path:** IDLE → W_EPC (mepc = trap_pc & ~3) → W_CAUSE (0x342) → W_TVAL (0x343) → W_STATUS (0x300) → REDIRECT → IDLE.
- **mstatus on trap:** bit 7 (MPIE) ← MIE, bit 3 (MIE) ← 0, bits 12:11 (MPP) ← 2'b11; all other bits unchanged from `mstatus_i`.
- **mret path:** IDLE → M_STATUS → REDIRECT → IDLE.
  - mstatus: MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
  - Target = `mepc_i & ~3`.
- **Trap target:**
  - If `mtvec_i[1:0]==2'b01`, `VECTORED_EN`=1, and the trap is an interrupt: `{mtvec_i[31:2],2'b00} + 4*cause[3:0]`, 32-bit wraparound.
  - Otherwise: `{mtvec_i[31:2],2'b00}`. MODE 1x is treated as direct.
- **Write-port arbitration:**
  - In IDLE, pipeline writes are forwarded registered: `pipe_*` appears on `csr_*` one cycle later, including in the cycle a trap is accepted (it belongs to an older instruction).
  - In all other states `pipe_wben` is dropped.
- Requests arriving in non-IDLE states are ignored. IRQs are level-sensitive and are re-evaluated on return to IDLE. A simultaneous exception and `mret` takes the exception.

## Timing
- **Reset values:** all outputs 0; state IDLE; latched cause/tval/pc registers 0. Asserting `rst` mid-sequence aborts it immediately, with no partial redirect.
- **Trap:** request sampled at edge N.
  - `flush`=1 in cycle N+1 only.
  - `stall`=1 in cycles N+1..N+5.
  - CSR writes land in cycles N+1..N+4, one per cycle.
  - `redirect_valid`=1 with `redirect_pc` in cycle N+5.
  - IDLE in cycle N+6.
- **mret:** `flush` and `stall` asserted in N+1; mstatus write in N+1; redirect in N+2 (stall held); IDLE in N+3.
- `csr_wben` is asserted for exactly one cycle per write.
- `mtvec_i` and `mepc_i` are sampled in the REDIRECT cycle. `mstatus_i` is sampled at acceptance.

## Structure
- **Package `trap_pkg`:**
  - CSR address constants: MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343.
  - mstatus bit indices: MIE 3, MPIE 7, MPP 12:11.
  - Interrupt cause codes: 7 and 11.
  - The state enum.
- **Sub-module `trap_cause_sel`:** combinational priority and cause encoder, with outputs take, is_irq, is_mret and mcause.

## Test plan
- **Pipeline write forwarding:** idle, `pipe_wben`=1, addr 0x300, data 0xA5A5A5A5 → next cycle `csr_wben`=1, addr 0x300, data 0xA5A5A5A5; `stall`=0.
- **Exception entry:** `exc_valid`, cause 2, pc 0x00000104, tval 0xDEADBEEF, mstatus 0x8, mtvec 0x100 → writes in order:
  - 0x341←0x104
  - 0x342←0x2
  - 0x343←0xDEADBEEF
  - 0x300←0x1880
  - then redirect 0x100 in cycle N+5.
- **Vectored timer interrupt:** `irq_timer`=1, mie 0x80, mstatus 0x8, mtvec 0x201 → mcause 0x80000007, tval 0, redirect 0x21C.
- **Masked interrupts:** mstatus MIE=0 with `irq_ext`=1 → no sequence, `stall` stays 0. Same result with MIE=1 and mie 0.
- **mret:** mstatus 0x1880, mepc 0x106 → write 0x300←0x1888, redirect 0x104 at N+2.
- **Collisions and reset:**
  - `pipe_wben` during W_CAUSE → dropped.
  - `exc_valid` together with `mret_valid` → trap path taken.
  - `rst` pulse during W_TVAL → all outputs 0, no redirect, IDLE afterwards.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// rtl/trap_sequencer_pkg.sv - trap_pkg: CSR addresses, mstatus fields, cause codes, sequencer states
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [3:0] IRQ_CAUSE_TIMER = 4'd7;
  localparam logic [3:0] IRQ_CAUSE_EXT   = 4'd11;

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS, REDIRECT
  } state_t;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - CSR write-port bundle shared by the pipeline side and the csr_handler side
interface trap_sequencer_if #(parameter int XLEN = 32);
  logic            wben;
  logic [11:0]     wbaddr;
  logic [XLEN-1:0] wbdata;

  modport master (output wben, output wbaddr, output wbdata);
  modport slave  (input  wben, input  wbaddr, input  wbdata);
endinterface

// File: rtl/trap_sequencer_cause_sel.sv
// rtl/trap_sequencer_cause_sel.sv - trap_cause_sel: request priority and mcause encoding
import trap_pkg::*;

module trap_cause_sel (
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        mret_valid,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        mie_mtie,
  output logic        take,
  output logic        is_irq,
  output logic        is_mret,
  output logic [31:0] mcause
);

  logic ext_pend;
  logic tmr_pend;

  assign ext_pend = irq_ext   && mstatus_mie && mie_meie;
  assign tmr_pend = irq_timer && mstatus_mie && mie_mtie;

  always_comb begin
    take    = 1'b0;
    is_irq  = 1'b0;
    is_mret = 1'b0;
    mcause  = 32'h0;
    if (exc_valid) begin
      take   = 1'b1;
      mcause = {28'h0, exc_cause};
    end else if (ext_pend) begin
      take   = 1'b1;
      is_irq = 1'b1;
      mcause = {1'b1, 27'h0, IRQ_CAUSE_EXT};
    end else if (tmr_pend) begin
      take   = 1'b1;
      is_irq = 1'b1;
      mcause = {1'b1, 27'h0, IRQ_CAUSE_TIMER};
    end else if (mret_valid) begin
      take    = 1'b1;
      is_mret = 1'b1;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap/mret sequencer owning the csr_handler write port
import trap_pkg::*;

module trap_sequencer #(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_tval,
  input  logic [31:0] trap_pc,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        mret_valid,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  trap_sequencer_if.slave  pipe,
  trap_sequencer_if.master csr,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  state_t      state, next_state;
  logic        hold, next_hold;
  logic [31:0] cause_q, tval_q, pc_q, status_q;
  logic        irq_q, mret_q;

  logic        take, is_irq, is_mret;
  logic [31:0] mcause;
  logic        latch;
  logic        nxt_wben, nxt_flush;
  logic [11:0] nxt_addr;
  logic [31:0] nxt_data;
  logic [31:0] status_live, tvec_base, target;
  logic        unused_mie_bits;

  assign unused_mie_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:0]};

  trap_cause_sel u_cause_sel (
    .exc_valid   (exc_valid),
    .exc_cause   (exc_cause),
    .irq_ext     (irq_ext),
    .irq_timer   (irq_timer),
    .mret_valid  (mret_valid),
    .mstatus_mie (mstatus_i[MSTATUS_MIE]),
    .mie_meie    (mie_i[11]),
    .mie_mtie    (mie_i[7]),
    .take        (take),
    .is_irq      (is_irq),
    .is_mret     (is_mret),
    .mcause      (mcause)
  );

  assign status_live = is_mret ? mret_mstatus(mstatus_i) : trap_mstatus(mstatus_i);
  assign tvec_base   = {mtvec_i[31:2], 2'b00};

  always_comb begin
    target = tvec_base;
    if (mret_q)
      target = mepc_i & ~32'h3;
    else if (VECTORED_EN && irq_q && mtvec_i[1:0] == 2'b01)
      target = tvec_base + {26'h0, cause_q[3:0], 2'b00};
  end

  // Output registers carry the write for the next cycle. A pipeline write that
  // arrives with an accepted request owns the first slot; hold then replays the
  // first sequence state one cycle later so neither write is lost.
  always_comb begin
    next_state = state;
    next_hold  = 1'b0;
    latch      = 1'b0;
    nxt_flush  = 1'b0;
    nxt_wben   = 1'b0;
    nxt_addr   = 12'h0;
    nxt_data   = 32'h0;
    unique case (state)
      IDLE: begin
        if (pipe.wben) begin
          nxt_wben = 1'b1;
          nxt_addr = pipe.wbaddr;
          nxt_data = pipe.wbdata;
        end
        if (take) begin
          latch      = 1'b1;
          nxt_flush  = 1'b1;
          next_state = is_mret ? M_STATUS : W_EPC;
          next_hold  = pipe.wben;
          if (!pipe.wben) begin
            nxt_wben = 1'b1;
            nxt_addr = is_mret ? CSR_MSTATUS : CSR_MEPC;
            nxt_data = is_mret ? status_live : (trap_pc & ~32'h3);
          end
        end
      end
      W_EPC: begin
        nxt_wben = 1'b1;
        if (hold) begin
          nxt_addr = CSR_MEPC;
          nxt_data = pc_q & ~32'h3;
        end else begin
          next_state = W_CAUSE;
          nxt_addr   = CSR_MCAUSE;
          nxt_data   = cause_q;
        end
      end
      W_CAUSE: begin
        next_state = W_TVAL;
        nxt_wben   = 1'b1;
        nxt_addr   = CSR_MTVAL;
        nxt_data   = tval_q;
      end
      W_TVAL: begin
        next_state = W_STATUS;
        nxt_wben   = 1'b1;
        nxt_addr   = CSR_MSTATUS;
        nxt_data   = status_q;
      end
      W_STATUS: next_state = REDIRECT;
      M_STATUS: begin
        if (hold) begin
          nxt_wben = 1'b1;
          nxt_addr = CSR_MSTATUS;
          nxt_data = status_q;
        end else begin
          next_state = REDIRECT;
        end
      end
      REDIRECT: next_state = IDLE;
      default:  next_state = IDLE;
    endcase

    stall          = (state != IDLE);
    redirect_valid = (state == REDIRECT);
    redirect_pc    = redirect_valid ? target : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold  <= 1'b0;
    end else begin
      state <= next_state;
      hold  <= next_hold;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr.wben   <= 1'b0;
      csr.wbaddr <= 12'h0;
      csr.wbdata <= 32'h0;
      flush      <= 1'b0;
      cause_q    <= 32'h0;
      tval_q     <= 32'h0;
      pc_q       <= 32'h0;
      status_q   <= 32'h0;
      irq_q      <= 1'b0;
      mret_q     <= 1'b0;
    end else begin
      csr.wben   <= nxt_wben;
      csr.wbaddr <= nxt_addr;
      csr.wbdata <= nxt_data;
      flush      <= nxt_flush;
      if (latch) begin
        cause_q  <= mcause;
        tval_q   <= is_irq ? 32'h0 : exc_tval;
        pc_q     <= trap_pc;
        status_q <= status_live;
        irq_q    <= is_irq;
        mret_q   <= is_mret;
      end
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed self-checking bench for trap_sequencer
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_valid = 1'b0;
  logic [3:0]  exc_cause = 4'h0;
  logic [31:0] exc_tval = 32'h0;
  logic [31:0] trap_pc = 32'h0;
  logic        irq_ext = 1'b0;
  logic        irq_timer = 1'b0;
  logic        mret_valid = 1'b0;
  logic [31:0] mstatus_i = 32'h0;
  logic [31:0] mie_i = 32'h0;
  logic [31:0] mtvec_i = 32'h0;
  logic [31:0] mepc_i = 32'h0;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;

  int vec_cnt = 0;
  int err_cnt = 0;

  trap_sequencer_if pipe_bus ();
  trap_sequencer_if csr_bus ();

  trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_tval       (exc_tval),
    .trap_pc        (trap_pc),
    .irq_ext        (irq_ext),
    .irq_timer      (irq_timer),
    .mret_valid     (mret_valid),
    .mstatus_i      (mstatus_i),
    .mie_i          (mie_i),
    .mtvec_i        (mtvec_i),
    .mepc_i         (mepc_i),
    .pipe           (pipe_bus),
    .csr            (csr_bus),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic [11:0] addr, input logic [31:0] data);
    expect_eq({tag, ".wben"}, {31'h0, csr_bus.wben}, 32'h1);
    expect_eq({tag, ".addr"}, {20'h0, csr_bus.wbaddr}, {20'h0, addr});
    expect_eq({tag, ".data"}, csr_bus.wbdata, data);
  endtask

  task automatic expect_quiet(input string tag);
    expect_eq({tag, ".wben"}, {31'h0, csr_bus.wben}, 32'h0);
    expect_eq({tag, ".stall"}, {31'h0, stall}, 32'h0);
    expect_eq({tag, ".redir"}, {31'h0, redirect_valid}, 32'h0);
  endtask

  // Caller has raised the request for the current cycle; this walks N+1..N+6.
  task automatic trap_seq(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                          input logic [31:0] tval, input logic [31:0] status,
                          input logic [31:0] target, input bit pipe_in_cause);
    tick();
    exc_valid = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; mret_valid = 1'b0;
    expect_eq({tag, ".flush1"}, {31'h0, flush}, 32'h1);
    expect_eq({tag, ".stall1"}, {31'h0, stall}, 32'h1);
    expect_wr({tag, ".epc"}, 12'h341, epc);
    tick();
    expect_eq({tag, ".flush2"}, {31'h0, flush}, 32'h0);
    expect_wr({tag, ".cause"}, 12'h342, cause);
    if (pipe_in_cause) begin
      pipe_bus.wben = 1'b1; pipe_bus.wbaddr = 12'h305; pipe_bus.wbdata = 32'h12345678;
    end
    tick();
    pipe_bus.wben = 1'b0;
    expect_wr({tag, ".tval"}, 12'h343, tval);
    tick();
    expect_wr({tag, ".status"}, 12'h300, status);
    tick();
    expect_eq({tag, ".wben5"}, {31'h0, csr_bus.wben}, 32'h0);
    expect_eq({tag, ".stall5"}, {31'h0, stall}, 32'h1);
    expect_eq({tag, ".rv5"}, {31'h0, redirect_valid}, 32'h1);
    expect_eq({tag, ".rpc5"}, redirect_pc, target);
    tick();
    expect_quiet({tag, ".idle6"});
  endtask

  initial begin
    pipe_bus.wben = 1'b0; pipe_bus.wbaddr = 12'h0; pipe_bus.wbdata = 32'h0;
    tick();
    expect_quiet("reset");
    expect_eq("reset.flush", {31'h0, flush}, 32'h0);
    expect_eq("reset.rpc", redirect_pc, 32'h0);
    rst = 1'b0;
    tick();

    pipe_bus.wben = 1'b1; pipe_bus.wbaddr = 12'h300; pipe_bus.wbdata = 32'hA5A5A5A5;
    tick();
    pipe_bus.wben = 1'b0;
    expect_wr("fwd", 12'h300, 32'hA5A5A5A5);
    expect_eq("fwd.stall", {31'h0, stall}, 32'h0);
    tick();
    expect_quiet("fwd.after");

    mstatus_i = 32'h8; mtvec_i = 32'h100;
    exc_valid = 1'b1; exc_cause = 4'd2; trap_pc = 32'h104; exc_tval = 32'hDEADBEEF;
    trap_seq("exc", 32'h104, 32'h2, 32'hDEADBEEF, 32'h1880, 32'h100, 1'b1);

    mie_i = 32'h80; mstatus_i = 32'h8; mtvec_i = 32'h201; trap_pc = 32'h200;
    irq_timer = 1'b1;
    trap_seq("tmr", 32'h200, 32'h80000007, 32'h0, 32'h1880, 32'h21C, 1'b0);

    mie_i = 32'h880; irq_ext = 1'b1; irq_timer = 1'b1; trap_pc = 32'h20B;
    trap_seq("ext", 32'h208, 32'h8000000B, 32'h0, 32'h1880, 32'h22C, 1'b0);

    mstatus_i = 32'h0; mie_i = 32'h800; irq_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); expect_quiet("mask.mie0"); end
    mstatus_i = 32'h8; mie_i = 32'h0;
    for (int i = 0; i < 3; i++) begin tick(); expect_quiet("mask.en0"); end
    irq_ext = 1'b0;

    mstatus_i = 32'h1880; mepc_i = 32'h106; mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    expect_eq("mret.flush", {31'h0, flush}, 32'h1);
    expect_eq("mret.stall1", {31'h0, stall}, 32'h1);
    expect_wr("mret.status", 12'h300, 32'h1888);
    tick();
    expect_eq("mret.wben2", {31'h0, csr_bus.wben}, 32'h0);
    expect_eq("mret.stall2", {31'h0, stall}, 32'h1);
    expect_eq("mret.rv", {31'h0, redirect_valid}, 32'h1);
    expect_eq("mret.rpc", redirect_pc, 32'h104);
    tick();
    expect_quiet("mret.idle");

    mstatus_i = 32'h8; mtvec_i = 32'h100;
    exc_valid = 1'b1; mret_valid = 1'b1; exc_cause = 4'd5; trap_pc = 32'h300; exc_tval = 32'h55;
    tick();
    exc_valid = 1'b0; mret_valid = 1'b0;
    expect_wr("both.epc", 12'h341, 32'h300);
    tick();
    expect_wr("both.cause", 12'h342, 32'h5);
    tick();
    expect_wr("both.tval", 12'h343, 32'h55);
    #1 rst = 1'b1;
    #1;
    expect_quiet("rst.async");
    expect_eq("rst.flush", {31'h0, flush}, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); expect_quiet("rst.after"); end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
